audio_fx_core: RTL and testbench

AUDIO_FX_CORE -- requirements
Module: audio_fx_core

---
 rtl/audio_fx_pkg.sv | 31 +++
 rtl/audio_fx_delay_ram.sv | 24 ++
 rtl/audio_fx_core.sv | 156 +++++++++++++++
 tb/tb_audio_fx_core.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_fx_pkg.sv
// Shared definitions for the audio effects core: effect mode encoding and
// the signed saturation helper used when AUDIO_FX_SAT_EN is defined.
package audio_fx_pkg;

    typedef enum logic [1:0] {
        FX_THRU = 2'd0,
        FX_MONO = 2'd1,
        FX_ECHO = 2'd2,
        FX_MUTE = 2'd3
    } fx_mode_e;

    // Clamp a sign-extended value into the signed range of 'width' bits.
    // The caller truncates the result back to 'width' bits.
    function automatic logic signed [63:0] sat_signed(
        input logic signed [63:0] value,
        input int unsigned        width
    );
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/audio_fx_delay_ram.sv
// Echo delay memory: single clock, one-cycle read latency, read-before-write
// on a shared address. Contents are deliberately not reset.
module audio_fx_delay_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]        i_wdata,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Return the old word at the address, then overwrite it with the new one.
    always_ff @(posedge clk) begin
        if (i_en) begin
            o_rdata        <= r_mem[i_addr];
            r_mem[i_addr]  <= i_wdata;
        end
    end

endmodule

// File: rtl/audio_fx_core.sv
// Stereo audio effects core: THRU / MONO / ECHO / MUTE with a 2-stage
// pipeline. Stage 1 captures the sample and mode and reads the delay line;
// stage 2 forms the effect result and registers it on the outputs.
// Build option: define AUDIO_FX_SAT_EN to saturate ECHO results instead of
// wrapping them to DATA_W bits.
module audio_fx_core
    import audio_fx_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int DELAY_DEPTH = 1024,
    parameter int ECHO_SHIFT  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     VALID,
    input  logic signed [DATA_W-1:0] left_in,
    input  logic signed [DATA_W-1:0] right_in,
    input  logic [1:0]               mode,
    output logic [DATA_W-1:0]        left_out,
    output logic [DATA_W-1:0]        right_out,
    output logic                     out_valid
);

    localparam int AW = $clog2(DELAY_DEPTH);

    // Stage 1 state
    logic [AW-1:0]             r_wr_ptr;
    logic                      r_fill;
    logic                      r_s1_valid;
    logic                      r_s1_fill;
    fx_mode_e                  r_s1_mode;
    logic signed [DATA_W-1:0]  r_s1_left;
    logic signed [DATA_W-1:0]  r_s1_right;

    // Stage 2 combinational results
    logic [2*DATA_W-1:0]       w_rd_data;
    logic signed [DATA_W-1:0]  w_del_l;
    logic signed [DATA_W-1:0]  w_del_r;
    logic signed [DATA_W-1:0]  w_echo_l;
    logic signed [DATA_W-1:0]  w_echo_r;
    logic signed [DATA_W:0]    w_sum_l;
    logic signed [DATA_W:0]    w_sum_r;
    logic signed [DATA_W:0]    w_mono_sum;
    logic [DATA_W-1:0]         w_echo_res_l;
    logic [DATA_W-1:0]         w_echo_res_r;
    logic [DATA_W-1:0]         w_nxt_l;
    logic [DATA_W-1:0]         w_nxt_r;

    audio_fx_delay_ram #(
        .DATA_W (2*DATA_W),
        .DEPTH  (DELAY_DEPTH)
    ) u_delay_ram (
        .clk     (clk),
        .i_en    (VALID),
        .i_addr  (r_wr_ptr),
        .i_wdata ({left_in, right_in}),
        .o_rdata (w_rd_data)
    );

    // Stage 1: capture the sample, its mode and the fill state; advance the delay pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_fill     <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_fill  <= 1'b0;
            r_s1_mode  <= FX_THRU;
            r_s1_left  <= '0;
            r_s1_right <= '0;
        end else begin
            r_s1_valid <= VALID;
            if (VALID) begin
                r_s1_mode  <= fx_mode_e'(mode);
                r_s1_left  <= left_in;
                r_s1_right <= right_in;
                // Fill state before this write: the word being read is valid
                // only once every location has been written at least once.
                r_s1_fill  <= r_fill;
                r_wr_ptr   <= r_wr_ptr + AW'(1);
                if (r_wr_ptr == AW'(DELAY_DEPTH - 1)) begin
                    r_fill <= 1'b1;
                end
            end
        end
    end

    // Stage 2 datapath: masked delayed term, echo and mono sums at DATA_W+1 bits.
    always_comb begin
        w_del_l = '0;
        w_del_r = '0;
        if (r_s1_fill) begin
            w_del_l = $signed(w_rd_data[2*DATA_W-1:DATA_W]);
            w_del_r = $signed(w_rd_data[DATA_W-1:0]);
        end else begin
            w_del_l = '0;
            w_del_r = '0;
        end
        w_echo_l   = w_del_l >>> ECHO_SHIFT;
        w_echo_r   = w_del_r >>> ECHO_SHIFT;
        w_sum_l    = (DATA_W+1)'(r_s1_left)  + (DATA_W+1)'(w_echo_l);
        w_sum_r    = (DATA_W+1)'(r_s1_right) + (DATA_W+1)'(w_echo_r);
        w_mono_sum = (DATA_W+1)'(r_s1_left)  + (DATA_W+1)'(r_s1_right);
`ifdef AUDIO_FX_SAT_EN
        w_echo_res_l = DATA_W'(sat_signed(64'(w_sum_l), unsigned'(DATA_W)));
        w_echo_res_r = DATA_W'(sat_signed(64'(w_sum_r), unsigned'(DATA_W)));
`else
        w_echo_res_l = DATA_W'(w_sum_l);
        w_echo_res_r = DATA_W'(w_sum_r);
`endif
    end

    // Stage 2 effect select, driven by the mode that travelled with the sample.
    always_comb begin
        w_nxt_l = '0;
        w_nxt_r = '0;
        case (r_s1_mode)
            FX_THRU: begin
                w_nxt_l = r_s1_left;
                w_nxt_r = r_s1_right;
            end
            FX_MONO: begin
                // Arithmetic shift by one of the DATA_W+1 bit sum.
                w_nxt_l = w_mono_sum[DATA_W:1];
                w_nxt_r = w_mono_sum[DATA_W:1];
            end
            FX_ECHO: begin
                w_nxt_l = w_echo_res_l;
                w_nxt_r = w_echo_res_r;
            end
            FX_MUTE: begin
                w_nxt_l = '0;
                w_nxt_r = '0;
            end
            default: begin
                w_nxt_l = '0;
                w_nxt_r = '0;
            end
        endcase
    end

    // Output registers: update only when a sample leaves stage 1, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            left_out  <= '0;
            right_out <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                left_out  <= w_nxt_l;
                right_out <= w_nxt_r;
            end
        end
    end

endmodule

// File: tb/tb_audio_fx_core.sv
// Self-checking bench for audio_fx_core (DATA_W=16, DELAY_DEPTH=4, ECHO_SHIFT=1).
// Expected output pairs are queued as samples are driven and compared by a
// monitor when out_valid rises; each test task also checks timing inline.
module tb_audio_fx_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        VALID;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic [1:0]  mode;
    logic [15:0] left_out;
    logic [15:0] right_out;
    logic        out_valid;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    audio_fx_core #(
        .DATA_W      (16),
        .DELAY_DEPTH (4),
        .ECHO_SHIFT  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .VALID     (VALID),
        .left_in   (left_in),
        .right_in  (right_in),
        .mode      (mode),
        .left_out  (left_out),
        .right_out (right_out),
        .out_valid (out_valid)
    );

    // Scoreboard monitor: every out_valid pops one expected pair.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got L=%h R=%h, no output expected", left_out, right_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({left_out, right_out} !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard: got L=%h R=%h, expected L=%h R=%h",
                             left_out, right_out, mon_exp[31:16], mon_exp[15:0]);
                end
            end
        end
    end

    // Drive one VALID cycle; leaves VALID high so calls can run back to back.
    task automatic drive(input logic [15:0] l, input logic [15:0] r, input logic [1:0] m);
        VALID    = 1'b1;
        left_in  = l;
        right_in = r;
        mode     = m;
        @(posedge clk);
        #1;
    endtask

    // Drop VALID and put junk on the data inputs, which must be ignored.
    task automatic idle();
        VALID    = 1'b0;
        left_in  = 16'hDEAD;
        right_in = 16'hBEEF;
    endtask

    task automatic test_reset();
        rst = 1'b1; VALID = 1'b0; left_in = 16'h0000; right_in = 16'h0000; mode = 2'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
        checks++;
        if (left_out !== 16'h0000) begin errors++; $display("FAIL reset_left: got %h, expected 0000", left_out); end
        checks++;
        if (right_out !== 16'h0000) begin errors++; $display("FAIL reset_right: got %h, expected 0000", right_out); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_thru();
        exp_q.push_back({16'h1234, 16'hF000});
        drive(16'h1234, 16'hF000, 2'd0);
        idle();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL thru_early: out_valid got %b one cycle after VALID, expected 0", out_valid); end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL thru_latency: out_valid got %b two cycles after VALID, expected 1", out_valid); end
        @(posedge clk); #1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL thru_drain: %0d outputs missing, expected 0", exp_q.size()); end
    endtask

    task automatic test_mono();
        exp_q.push_back({16'h7FFF, 16'h7FFF});
        drive(16'h7FFF, 16'h7FFF, 2'd1);
        exp_q.push_back({16'hFFFF, 16'hFFFF});
        drive(16'h8000, 16'h7FFF, 2'd1);
        idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mono_drain: %0d outputs missing, expected 0", exp_q.size()); end
    endtask

    task automatic test_mute();
        exp_q.push_back({16'h0000, 16'h0000});
        drive(16'h1111, 16'h2222, 2'd3);
        idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mute_drain: %0d outputs missing, expected 0", exp_q.size()); end
    endtask

    task automatic test_mode_change();
        exp_q.push_back({16'h0AAA, 16'h0555});
        drive(16'h0AAA, 16'h0555, 2'd0);
        idle();
        mode = 2'd3;
        @(posedge clk); #1;
        exp_q.push_back({16'h0000, 16'h0000});
        drive(16'h0BBB, 16'h0CCC, 2'd3);
        idle();
        // MUTE on the mode pins while VALID is low must not affect the next sample.
        mode = 2'd3;
        repeat (2) begin @(posedge clk); #1; end
        exp_q.push_back({16'h0DDD, 16'h0EEE});
        drive(16'h0DDD, 16'h0EEE, 2'd0);
        idle();
        mode = 2'd3;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL mode_change_drain: %0d outputs missing, expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        drive(16'h5555, 16'h6666, 2'd0);
        idle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, left_out, right_out} !== 33'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got v=%b L=%h R=%h, expected all 0", out_valid, left_out, right_out);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        @(posedge clk); #1;
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_mid_discard: got %0d out_valid pulses, expected 0", seen); end
    endtask

    // Runs straight after the mid-operation reset: the delay memory still
    // holds old samples, so the first four outputs check the fill mask.
    task automatic test_echo_fill();
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] el;
        logic [15:0] er;
        for (int k = 1; k <= 5; k++) begin
            l  = 16'(100 * k);
            r  = 16'(-10 * k);
            el = (k == 5) ? 16'd550 : l;
            er = (k == 5) ? 16'(-55) : r;
            exp_q.push_back({el, er});
            drive(l, r, 2'd2);
        end
        idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL echo_fill_drain: %0d outputs missing, expected 0", exp_q.size()); end
    endtask

    task automatic test_echo_overflow();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({16'h7FFF, 16'h8000});
            drive(16'h7FFF, 16'h8000, 2'd0);
        end
`ifdef AUDIO_FX_SAT_EN
        exp_q.push_back({16'h7FFF, 16'h8000});
`else
        exp_q.push_back({16'hBFFE, 16'h4000});
`endif
        drive(16'h7FFF, 16'h8000, 2'd2);
        idle();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL echo_overflow_drain: %0d outputs missing, expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_thru();
        test_mono();
        test_mute();
        test_mode_change();
        test_reset_mid();
        test_echo_fill();
        test_echo_overflow();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
